program_preloader: RTL
======================

// Module: program_preloader
// PURPOSE
//  Parametrised program/data loader for the memory behind the fetcher/decoder path.
//  Accepts a valid/ready byte stream and writes it to memory starting at a base address.
//  Holds the CPU core in reset until the load completes.
//  With PRELOAD_VERIFY_EN, reads the loaded region back and checks a checksum before release.
// PARAMETERS
//  ADDR_WIDTH  16      memory address width; all address arithmetic is mod 2^ADDR_WIDTH
//  DATA_WIDTH  8       memory/stream word width; also the checksum width
//  BASE_ADDR   16'h0600 first address written (instruction region base)
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  reset      in   1           asynchronous, active-high reset
//  start      in   1           1-cycle pulse; starts a load of `len` words; ignored unless IDLE/DONE/ERROR
//  len        in   ADDR_WIDTH  word count, sampled when start is accepted
//  src_valid  in   1           stream word available
//  src_data   in   DATA_WIDTH  stream word
//  src_ready  out  1           loader accepts src_data this cycle (beat = valid & ready)
//  mem_addr   out  ADDR_WIDTH  memory address
//  mem_we     out  1           memory write strobe
//  mem_din    out  DATA_WIDTH  memory write data
//  mem_dout   in   DATA_WIDTH  memory read data; valid 1 cycle after mem_addr with mem_we=0
//  hold_cpu   out  1           holds the core in reset; drives the core's reset_n low
//  busy       out  1           load or verify in progress
//  done       out  1           level; load (and verify) finished OK
//  error      out  1           level; verify checksum mismatch
//  csum       out  DATA_WIDTH  running mod-2^DATA_WIDTH sum of accepted words
// BEHAVIOUR
//  Reset values: state=IDLE, src_ready=0, mem_we=0, mem_addr=0, mem_din=0, hold_cpu=1, busy=0,
//   done=0, error=0, csum=0. Reset mid-operation aborts immediately. A partial load is not cleaned up.
//  States: IDLE, WRITE, VERIFY (only with PRELOAD_VERIFY_EN), DONE, ERROR.
//  IDLE/DONE/ERROR + start: cnt<=len, ptr<=BASE_ADDR, csum<=0, done<=0, error<=0, hold_cpu<=1.
//   Next state is WRITE, or DONE if len==0, in which case done is set on the next cycle.
//  WRITE: src_ready=1 while cnt!=0. On each beat, in the same cycle: mem_we=1, mem_addr=ptr, mem_din=src_data.
//   Also on each beat: ptr<=ptr+1 (wraps FFFF->0000), cnt<=cnt-1, csum<=csum+src_data.
//   No beat: mem_we=0 and no state change. Arbitrary src_valid gaps are allowed.
//   After the last beat, src_ready drops on the next cycle. Next state is VERIFY if enabled, else DONE.
//  VERIFY: mem_we=0. One address per cycle from BASE_ADDR for len cycles.
//   Read sum accumulates mem_dout one cycle behind the address (1-cycle pipeline).
//   Verify phase lasts len+1 cycles, then read sum is compared with csum: equal -> DONE, else ERROR.
//  DONE: busy=0, done=1, hold_cpu=0 (core released), src_ready=0.
//  ERROR: busy=0, error=1, hold_cpu stays 1; only start or reset leaves this state.
//  busy=1 exactly in WRITE/VERIFY. start during busy is ignored; no re-sample of len.
//  start and last beat in the same cycle: start ignored, the beat completes normally.
//  Latency: len==N with no gaps gives DONE N+1 cycles after start (no verify) or 2N+2 cycles (verify).
// CONFIGURATION
//  PRELOAD_VERIFY_EN defined: VERIFY state present; readback checksum gates core release.
//  Undefined: WRITE goes straight to DONE. error is tied 0 and never asserts.
// TESTING
//  1 len=4, BASE 0600, stream A9 05 85 10 no gaps -> writes 0600..0603, csum=43, done=1, hold_cpu=0.
//  2 Same stream with src_valid low on alternate cycles -> identical mem contents and csum=43.
//    mem_we is high only on beats.
//  3 (verify) After the write phase, bench corrupts mem[0602]=00 -> readback sum BE != 43.
//    Expect error=1, done=0, hold_cpu=1.
//  4 len=0 + start -> no mem_we, done=1 next cycle, csum=00.
//  5 BASE_ADDR=FFFE, len=4 -> writes to FFFE, FFFF, 0000, 0001; done=1.
//  6 reset pulsed after 2 of 4 beats -> all outputs at reset values asynchronously.
//    start pulse during WRITE is ignored (cnt unchanged).

Source files
------------

// File: rtl/program_preloader_if.sv
// Stream, memory and status signals of the program preloader.
// The slave modport is the loader; the master modport is the stream source, memory and core side.

interface program_preloader_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] len;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  hold_cpu;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] csum;

  modport slave (
    input  start, len, src_valid, src_data, mem_dout,
    output src_ready, mem_addr, mem_we, mem_din, hold_cpu, busy, done, error, csum
  );

  modport master (
    output start, len, src_valid, src_data, mem_dout,
    input  src_ready, mem_addr, mem_we, mem_din, hold_cpu, busy, done, error, csum
  );
endinterface

// File: rtl/program_preloader.sv
// Streams `len` words into memory from BASE_ADDR and holds the core in reset until finished.
// Define PRELOAD_VERIFY_EN to add a readback checksum pass that gates core release.

module program_preloader #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0600
) (
  input logic                clk,
  input logic                reset,
  program_preloader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
`ifdef PRELOAD_VERIFY_EN
    StVerify,
`endif
    StDone,
    StError
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CntOne = ADDR_WIDTH'(1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  src_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  hold_q;
  logic                  beat;
  logic                  can_start;

  assign beat      = bus.src_valid & src_ready_q;
  assign can_start = bus.start & (state_q inside {StIdle, StDone, StError});

`ifdef PRELOAD_VERIFY_EN
  logic [ADDR_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] rsum_q;
  logic [DATA_WIDTH-1:0] rsum_next;
  logic                  rd_vld_q;
  logic                  error_q;

  // Read data arrives one cycle after its address, so it is qualified by rd_vld_q.
  assign rsum_next = rsum_q + (rd_vld_q ? bus.mem_dout : '0);
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      csum_q      <= '0;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= 1'b1;
`ifdef PRELOAD_VERIFY_EN
      len_q       <= '0;
      rsum_q      <= '0;
      rd_vld_q    <= 1'b0;
      error_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (can_start) begin
            cnt_q  <= bus.len;
            ptr_q  <= BASE_ADDR;
            csum_q <= '0;
`ifdef PRELOAD_VERIFY_EN
            len_q   <= bus.len;
            error_q <= 1'b0;
`endif
            if (bus.len == '0) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              hold_q      <= 1'b0;
              busy_q      <= 1'b0;
              src_ready_q <= 1'b0;
            end else begin
              state_q     <= StWrite;
              done_q      <= 1'b0;
              hold_q      <= 1'b1;
              busy_q      <= 1'b1;
              src_ready_q <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (beat) begin
            csum_q <= csum_q + bus.src_data;
            if (cnt_q == CntOne) begin
              src_ready_q <= 1'b0;
`ifdef PRELOAD_VERIFY_EN
              state_q  <= StVerify;
              ptr_q    <= BASE_ADDR;
              cnt_q    <= len_q;
              rsum_q   <= '0;
              rd_vld_q <= 1'b0;
`else
              state_q <= StDone;
              ptr_q   <= ptr_q + CntOne;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
`endif
            end else begin
              ptr_q <= ptr_q + CntOne;
              cnt_q <= cnt_q - CntOne;
            end
          end
        end
`ifdef PRELOAD_VERIFY_EN
        StVerify: begin
          rsum_q   <= rsum_next;
          rd_vld_q <= (cnt_q != '0);
          if (cnt_q != '0) begin
            ptr_q <= ptr_q + CntOne;
            cnt_q <= cnt_q - CntOne;
          end else begin
            busy_q <= 1'b0;
            if (rsum_next == csum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write strobe and data follow the beat combinationally so each word lands in its own cycle.
  always_comb begin
    bus.mem_addr = '0;
    if (state_q == StWrite) bus.mem_addr = ptr_q;
`ifdef PRELOAD_VERIFY_EN
    if (state_q == StVerify) bus.mem_addr = ptr_q;
`endif
  end

  assign bus.mem_we    = beat;
  assign bus.mem_din   = beat ? bus.src_data : '0;
  assign bus.src_ready = src_ready_q;
  assign bus.hold_cpu  = hold_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.csum      = csum_q;

endmodule
